// File: rtl/gpio_intc.sv
// gpio_intc: latches GPIO interrupt lines into pending bits, arbitrates by priority
// and hands one interrupt to the CPU through a claim/complete register handshake.
module gpio_intc #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic               irq_o,
    input  logic               reg_we_i,
    input  logic               reg_re_i,
    input  logic [31:0]        reg_wdata_i,
    input  logic [3:0]         reg_be_i,
    input  logic [31:0]        reg_addr_i,
    output logic [31:0]        reg_rdata_o
);

    localparam int PW = 3 * NUM_SRC;

    localparam logic [7:0] A_EN   = 8'h00;
    localparam logic [7:0] A_PRIO = 8'h04;
    localparam logic [7:0] A_THR  = 8'h08;
    localparam logic [7:0] A_PEND = 8'h0C;
    localparam logic [7:0] A_CLM  = 8'h10;
    localparam logic [7:0] A_INS  = 8'h14;

    logic [NUM_SRC-1:0] r_enable;
    logic [PW-1:0]      r_prio;
    logic [2:0]         r_thresh;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_inservice;
    logic               r_irq;
    logic [31:0]        r_rdata;

    logic [7:0]         w_addr;
    logic [31:0]        w_wmask;
    logic               w_rd;
    logic               w_claim;
    logic               w_cmp;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_win_oh;
    logic [NUM_SRC-1:0] w_cmp_oh;
    logic [3:0]         w_win_id;
    logic [2:0]         w_best;
    logic [31:0]        w_rmux;
    logic               w_unused;

    assign w_addr   = reg_addr_i[7:0];
    assign w_wmask  = {{8{reg_be_i[3]}}, {8{reg_be_i[2]}},
                       {8{reg_be_i[1]}}, {8{reg_be_i[0]}}};
    // A simultaneous write wins: the read is squashed entirely.
    assign w_rd     = reg_re_i & ~reg_we_i;
    assign w_claim  = w_rd && (w_addr == A_CLM) && (|w_eligible);
    assign w_cmp    = reg_we_i && (w_addr == A_CLM) && reg_be_i[0];
    assign w_unused = ^{reg_addr_i[31:8], w_wmask, reg_wdata_i};

    // Strictly-greater compare keeps the lowest ID on priority ties.
    always_comb begin
        w_eligible = '0;
        w_win_oh   = '0;
        w_cmp_oh   = '0;
        w_win_id   = 4'd0;
        w_best     = 3'd0;
        for (int n = 0; n < NUM_SRC; n++) begin
            w_eligible[n] = r_pending[n] & r_enable[n] &
                            (r_prio[3*n +: 3] > r_thresh);
            if (w_eligible[n] && (r_prio[3*n +: 3] > w_best)) begin
                w_best   = r_prio[3*n +: 3];
                w_win_id = 4'(n + 1);
                w_win_oh = '0;
                w_win_oh[n] = 1'b1;
            end
            if (w_cmp && (reg_wdata_i[3:0] == 4'(n + 1))) begin
                w_cmp_oh[n] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rmux = 32'd0;
        case (w_addr)
            A_EN:    w_rmux = 32'(r_enable);
            A_PRIO:  w_rmux = 32'(r_prio);
            A_THR:   w_rmux = {29'd0, r_thresh};
            A_PEND:  w_rmux = 32'(r_pending);
            A_CLM:   w_rmux = {28'd0, w_win_id};
            A_INS:   w_rmux = 32'(r_inservice);
            default: w_rmux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enable <= '0;
            r_prio   <= '0;
            r_thresh <= '0;
        end else if (reg_we_i) begin
            if (w_addr == A_EN)
                r_enable <= (r_enable & ~w_wmask[NUM_SRC-1:0]) |
                            (reg_wdata_i[NUM_SRC-1:0] & w_wmask[NUM_SRC-1:0]);
            if (w_addr == A_PRIO)
                r_prio <= (r_prio & ~w_wmask[PW-1:0]) |
                          (reg_wdata_i[PW-1:0] & w_wmask[PW-1:0]);
            if (w_addr == A_THR)
                r_thresh <= (r_thresh & ~w_wmask[2:0]) |
                            (reg_wdata_i[2:0] & w_wmask[2:0]);
        end
    end

    // Gateway: a line in service or already pending cannot re-latch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending   <= '0;
            r_inservice <= '0;
            r_irq       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_pending   <= (r_pending & ~(w_claim ? w_win_oh : '0)) |
                           (irq_src_i & ~r_pending & ~r_inservice);
            r_inservice <= (r_inservice & ~w_cmp_oh) |
                           (w_claim ? w_win_oh : '0);
            r_irq       <= |w_eligible;
            r_rdata     <= w_rd ? w_rmux : 32'd0;
        end
    end

    assign irq_o       = r_irq;
    assign reg_rdata_o = r_rdata;

endmodule
